// File: rtl/ones_counter_pkg.sv
// ----------------------------------------------------------------------------
// ones_counter_pkg
// Shared definitions for the sequential population counter:
//   - state_e   : FSM state encoding (IDLE / COUNT / DONE)
//   - NIBBLE_W  : number of data bits examined per COUNT cycle
//   - nibble_popcount() : set-bit count of one nibble (0..4)
// ----------------------------------------------------------------------------
package ones_counter_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Number of ones in a single nibble; the result always fits in 3 bits.
   function automatic logic [2:0] nibble_popcount(input logic [NIBBLE_W-1:0] nib);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < NIBBLE_W; i++) begin
         cnt = cnt + {2'b00, nib[i]};
      end
      return cnt;
   endfunction

endpackage : ones_counter_pkg

// File: rtl/ones_acc_add.sv
// ----------------------------------------------------------------------------
// full_adder
// The 1-bit full-adder cell used as the building block of ripple adders.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum, o_cout   : sum bit and carry out
// ----------------------------------------------------------------------------
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : full_adder

// ----------------------------------------------------------------------------
// ones_acc_add
// W-bit ripple-carry adder built as a chain of full_adder cells; it is the
// accumulation datapath of the population counter.
//   i_dataA, i_dataB : W-bit addends
//   i_cin            : carry into bit 0
//   o_sum            : W-bit sum
//   o_cout           : carry out of the MSB
// ----------------------------------------------------------------------------
module ones_acc_add #(
   parameter int W = 6
) (
   output logic         o_cout,
   output logic [W-1:0] o_sum,
   input  logic [W-1:0] i_dataA,
   input  logic [W-1:0] i_dataB,
   input  logic         i_cin
);

   logic [W:0] carry;

   assign carry[0] = i_cin;

   for (genvar g = 0; g < W; g++) begin : g_bit
      full_adder u_fa (
         .i_a    (i_dataA[g]),
         .i_b    (i_dataB[g]),
         .i_cin  (carry[g]),
         .o_sum  (o_sum[g]),
         .o_cout (carry[g+1])
      );
   end

   assign o_cout = carry[W];

endmodule : ones_acc_add

// File: rtl/ones_counter_seq.sv
// ----------------------------------------------------------------------------
// ones_counter_seq
// Sequential population counter. Accepts one word on a valid/ready input,
// counts its set bits one nibble per cycle into an accumulator through
// ones_acc_add, and presents the total on a valid/ready output.
//   i_clk, i_rst_n     : clock (rising edge), async active-low reset
//   i_valid, o_ready   : input handshake, i_data captured when both high
//   i_data             : DATA_W-bit word to count
//   o_valid, i_ready   : output handshake, o_count held until i_ready
//   o_count            : number of ones in the accepted word (0 unless DONE)
//   o_busy             : high while the count is in progress
// DATA_W must be a multiple of 4 and at least 4; 2**CNT_W must exceed DATA_W.
// ----------------------------------------------------------------------------
module ones_counter_seq
   import ones_counter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_busy
);

   localparam int STEPS  = DATA_W / NIBBLE_W;
   localparam int STEP_W = $clog2(STEPS + 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    acc_q,   acc_d;
   logic [STEP_W-1:0]   step_q,  step_d;

   logic [CNT_W-1:0]    nib_cnt;
   logic [CNT_W-1:0]    add_sum;
   logic                add_cout_unused;

   // Popcount of the nibble currently at the bottom of the shift register.
   assign nib_cnt = CNT_W'(nibble_popcount(shift_q[NIBBLE_W-1:0]));

   // The accumulator can never exceed DATA_W, so the carry out is dropped.
   ones_acc_add #(
      .W (CNT_W)
   ) u_acc_add (
      .o_cout  (add_cout_unused),
      .o_sum   (add_sum),
      .i_dataA (acc_q),
      .i_dataB (nib_cnt),
      .i_cin   (1'b0)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      step_d  = step_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               shift_d = i_data;
               acc_d   = '0;
               step_d  = STEP_W'(STEPS);
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            shift_d = shift_q >> NIBBLE_W;
            acc_d   = add_sum;
            step_d  = step_q - 1'b1;
            // step_q==1 means this cycle adds the last nibble.
            if (step_q == STEP_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: datapath registers are cleared too, so a word in flight leaves no trace.
         state_q <= ST_IDLE;
         shift_q <= '0;
         acc_q   <= '0;
         step_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
      end
   end

   // Outputs decode from state and registered data only.
   assign o_ready = (state_q == ST_IDLE);
   assign o_busy  = (state_q == ST_COUNT);
   assign o_valid = (state_q == ST_DONE);
   assign o_count = (state_q == ST_DONE) ? acc_q : '0;

endmodule : ones_counter_seq

// File: tb/tb_ones_counter_seq.sv
// ----------------------------------------------------------------------------
// tb_ones_counter_seq
// Directed bench for ones_counter_seq with DATA_W=32, CNT_W=6. Inputs are
// driven and outputs sampled on the falling edge, away from the active edge.
// ----------------------------------------------------------------------------
module tb_ones_counter_seq;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;
   localparam int LAT    = DATA_W / 4;

   logic              clk;
   logic              rst_n;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data;
   logic              o_valid;
   logic              i_ready;
   logic [CNT_W-1:0]  o_count;
   logic              o_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_cnt  = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  exp_count;
   } vec_t;

   vec_t vecs[7];

   ones_counter_seq #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_count (o_count),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sends one word with i_ready=1 and checks latency, result and return to IDLE.
   // Entered and left on a falling edge with the DUT in IDLE.
   task automatic run_word(input string tag, input logic [DATA_W-1:0] data,
                           input logic [CNT_W-1:0] exp);
      int cyc;
      check({tag, " ready_before"}, 32'(o_ready), 32'd1);
      i_data  = data;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(negedge clk);               // accept edge T0 has passed
      i_valid = 1'b0;
      check({tag, " busy_after_accept"}, {30'd0, o_busy, o_ready}, 32'b10);
      cyc = 0;
      while (!o_valid && cyc < 3 * LAT) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(LAT));
      check({tag, " count"}, 32'(o_count), 32'(exp));
      @(negedge clk);               // output handshake edge has passed
      check({tag, " idle_after"}, {29'd0, o_valid, o_ready, o_busy}, 32'b010);
      check({tag, " count_cleared"}, 32'(o_count), 32'd0);
   endtask

   initial begin
      int cyc;
      int n_acc;
      int n_out;
      int acc_at[2];
      logic [CNT_W-1:0] outs[2];

      vecs[0] = '{32'h0000_0000, 6'd0};
      vecs[1] = '{32'hFFFF_FFFF, 6'd32};
      vecs[2] = '{32'hA5A5_0F01, 6'd13};
      vecs[3] = '{32'h1234_5678, 6'd13};
      vecs[4] = '{32'hF000_0000, 6'd4};
      vecs[5] = '{32'h0000_0001, 6'd1};
      vecs[6] = '{32'h8000_0001, 6'd2};

      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;

      // Reset state.
      @(negedge clk);
      check("reset outputs", {28'd0, o_ready, o_valid, o_busy, |o_count}, 32'b1000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after release ready", 32'(o_ready), 32'd1);

      // Table-driven single words.
      for (int i = 0; i < 7; i++) begin
         run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_count);
      end

      // Backpressure, with i_valid offering a stray word during COUNT and DONE.
      i_data  = 32'hA5A5_0F01;
      i_valid = 1'b1;
      i_ready = 1'b0;
      @(negedge clk);
      i_data = 32'h0000_0001;
      cyc = 0;
      while (!o_valid && cyc < 3 * LAT) begin
         check("bp ready_low_in_count", 32'(o_ready), 32'd0);
         @(negedge clk);
         cyc++;
      end
      check("bp latency", 32'(cyc), 32'(LAT));
      for (int k = 0; k < 5; k++) begin
         check("bp held_valid", 32'(o_valid), 32'd1);
         check("bp held_count", 32'(o_count), 32'd13);
         check("bp ready_low_in_done", 32'(o_ready), 32'd0);
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      check("bp handshake", {30'd0, o_valid, o_ready}, 32'b01);
      @(negedge clk);
      check("bp stray_not_accepted", {30'd0, o_busy, o_ready}, 32'b01);

      // Reset in the middle of a count.
      i_data  = 32'hFFFF_FFFF;
      i_valid = 1'b1;
      @(negedge clk);               // after T0
      i_valid = 1'b0;
      repeat (4) @(negedge clk);    // after T4
      rst_n = 1'b0;
      #1;
      check("mid_reset outputs", {28'd0, o_valid, o_busy, o_ready, |o_count}, 32'b0010);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_reset no_output", {30'd0, o_valid, o_busy}, 32'b00);
      run_word("post_reset", 32'h8000_0001, 6'd2);

      // Back-to-back words with i_valid held high.
      n_acc   = 0;
      n_out   = 0;
      acc_at  = '{0, 0};
      outs    = '{'0, '0};
      i_data  = 32'h0000_000F;
      i_valid = 1'b1;
      i_ready = 1'b1;
      for (int n = 0; n < 4 * LAT && n_out < 2; n++) begin
         if (o_ready && i_valid && n_acc < 2) begin
            acc_at[n_acc] = cyc_cnt + 1;
            n_acc++;
         end
         if (o_valid) begin
            outs[n_out] = o_count;
            n_out++;
         end
         @(negedge clk);
         if (n_acc == 1) i_data = 32'h0000_00FF;
         if (n_acc == 2) i_valid = 1'b0;
      end
      check("b2b outputs_seen", 32'(n_out), 32'd2);
      check("b2b count0", 32'(outs[0]), 32'd4);
      check("b2b count1", 32'(outs[1]), 32'd8);
      check("b2b accept_spacing", 32'(acc_at[1] - acc_at[0]), 32'(LAT + 2));
      @(negedge clk);
      check("b2b idle_after", {30'd0, o_valid, o_ready}, 32'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ones_counter_seq
